// File: rtl/ldm_stm_seq.sv
// Sequencer for ARM LDM/STM block transfers: walks the register list lowest-first, one beat per handshake.
// Optional macro LDM_STM_PC_LOAD_EN enables the pc_load pulse for loads that include R15.
module ldm_stm_seq #(
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       reg_list,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              p_bit,
  input  logic              u_bit,
  input  logic              w_bit,
  input  logic              l_bit,
  input  logic              mem_ready,
  input  logic              mem_abort,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        reg_idx,
  output logic              rf_we,
  output logic              done,
  output logic              abort_flag,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              pc_load
);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, FIN} state_t;

  state_t            state;
  logic [15:0]       work_list;
  logic [ADDR_W-1:0] base_q;
  logic              p_q, u_q, w_q, l_q;
  logic [4:0]        n_count;
  logic [ADDR_W-1:0] step, span, first_addr;
  logic [15:0]       remaining;
  logic              beat_ok, last_beat;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  // The block always occupies [lowest, lowest + 4n) and is walked upward, so
  // only the lowest address depends on the P/U mode.
  always_comb begin
    n_count = popcount16(work_list);
    step    = ADDR_W'(WORD_BYTES);
    span    = ADDR_W'(n_count) * step;
    case ({p_q, u_q})
      2'b01:   first_addr = base_q;
      2'b11:   first_addr = base_q + step;
      2'b00:   first_addr = base_q - span + step;
      default: first_addr = base_q - span;
    endcase
    remaining = work_list & ~(16'h0001 << reg_idx);
    beat_ok   = (state == XFER) && mem_ready && !mem_abort;
    last_beat = (remaining == 16'h0000);
  end

  assign rf_we = mem_req & mem_ready & l_q & ~mem_abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      done       <= 1'b0;
      abort_flag <= 1'b0;
      wb_en      <= 1'b0;
      mem_addr   <= '0;
      wb_addr    <= '0;
      reg_idx    <= '0;
      work_list  <= '0;
      base_q     <= '0;
      p_q        <= 1'b0;
      u_q        <= 1'b0;
      w_q        <= 1'b0;
      l_q        <= 1'b0;
    end else begin
      done  <= 1'b0;
      wb_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work_list <= reg_list;
            base_q    <= base_addr;
            p_q       <= p_bit;
            u_q       <= u_bit;
            w_q       <= w_bit;
            l_q       <= l_bit;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          wb_addr  <= u_q ? (base_q + span) : (base_q - span);
          mem_addr <= first_addr;
          reg_idx  <= lowest_set(work_list);
          if (n_count == 5'd0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            mem_req <= 1'b1;
            mem_we  <= ~l_q;
            state   <= XFER;
          end
        end
        XFER: begin
          // An abort wins over mem_ready and never advances the list.
          if (mem_abort) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            abort_flag <= 1'b1;
            state      <= FIN;
          end else if (mem_ready) begin
            work_list <= remaining;
            mem_addr  <= mem_addr + step;
            if (last_beat) begin
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              wb_en   <= w_q;
              state   <= FIN;
            end else begin
              reg_idx <= lowest_set(remaining);
            end
          end
        end
        FIN: begin
          abort_flag <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LDM_STM_PC_LOAD_EN
  // R15 is always the final beat, so a clean last load of R15 means the PC changed.
  always_ff @(posedge clk) begin
    if (rst) pc_load <= 1'b0;
    else     pc_load <= beat_ok && last_beat && l_q && (reg_idx == 4'd15);
  end
`else
  assign pc_load = 1'b0;
`endif

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Self-checking bench for ldm_stm_seq: directed vector table, reset corner case and
// randomized transactions checked against an address-range model of block transfers.
module tb_ldm_stm_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] reg_list;
  logic [31:0] base_addr;
  logic        p_bit, u_bit, w_bit, l_bit;
  logic        mem_ready, mem_abort;
  logic        busy, mem_req, mem_we, rf_we, done, abort_flag, wb_en, pc_load;
  logic [31:0] mem_addr, wb_addr;
  logic [3:0]  reg_idx;

  int check_count = 0;
  int pass_count  = 0;

  typedef struct {
    logic [15:0] list;
    logic [31:0] base;
    logic        p, u, w, l;
    int          waits;
    int          abort_at;
    bit          hold_start;
    logic [31:0] exp_first;
    logic [31:0] exp_wb;
    bit          exp_wb_en;
  } vec_t;

  vec_t vecs[8];

  ldm_stm_seq #(.ADDR_W(32), .WORD_BYTES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .reg_list(reg_list), .base_addr(base_addr),
    .p_bit(p_bit), .u_bit(u_bit), .w_bit(w_bit), .l_bit(l_bit),
    .mem_ready(mem_ready), .mem_abort(mem_abort),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .reg_idx(reg_idx), .rf_we(rf_we), .done(done), .abort_flag(abort_flag),
    .wb_en(wb_en), .wb_addr(wb_addr), .pc_load(pc_load)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish (got running, required finished)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // A block transfer covers the n words [low, low + 4n); P/U only choose where low sits.
  function automatic void model_txn(input logic [15:0] list, input logic [31:0] base,
                                    input logic p, input logic u, output int n,
                                    output logic [31:0] first, output logic [31:0] wb);
    logic [31:0] span;
    n    = $countones(list);
    span = 32'(n * 4);
    if (u) first = p ? base + 32'd4 : base;
    else   first = p ? base - span : base - span + 32'd4;
    wb = u ? base + span : base - span;
  endfunction

  task automatic applyStimulus(input vec_t v);
    int          n, cyc, b, stall_left, last_hs, rf_count, issued, k;
    int          exp_idx[16];
    logic [31:0] first_m, wb_m, held_addr;
    logic [3:0]  held_idx;
    logic        exp_pc;
    bit          fresh, finished;

    model_txn(v.list, v.base, v.p, v.u, n, first_m, wb_m);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      exp_idx[i] = 0;
      if (v.list[i]) begin
        exp_idx[k] = i;
        k++;
      end
    end

    @(negedge clk);
    reg_list = v.list; base_addr = v.base;
    p_bit = v.p; u_bit = v.u; w_bit = v.w; l_bit = v.l;
    start = 1'b1;
    @(negedge clk);
    if (!v.hold_start) start = 1'b0;
    cyc = 1;
    checkOutput("busy_in_setup", busy, 1);
    checkOutput("no_req_in_setup", mem_req, 0);

    b = 0; fresh = 1; stall_left = v.waits; last_hs = 0;
    rf_count = 0; issued = 0; finished = 0;
    held_idx = '0; held_addr = '0;
    while (!finished) begin
      if (cyc == 2) checkOutput("first_req_latency", mem_req, 32'(n > 0));
      if (done) begin
        checkOutput("done_cycle", cyc, (n == 0) ? 2 : last_hs + 1);
        checkOutput("beats_issued", issued, (v.abort_at >= 0) ? v.abort_at + 1 : n);
        checkOutput("rf_we_count", rf_count, v.l ? ((v.abort_at >= 0) ? v.abort_at : n) : 0);
        checkOutput("busy_at_done", busy, 0);
        checkOutput("req_at_done", mem_req, 0);
        checkOutput("abort_flag", abort_flag, 32'(v.abort_at >= 0));
        checkOutput("wb_en", wb_en, v.exp_wb_en);
        if (v.abort_at < 0) checkOutput("wb_addr", wb_addr, v.exp_wb);
`ifdef LDM_STM_PC_LOAD_EN
        exp_pc = v.l && v.list[15] && (v.abort_at < 0);
`else
        exp_pc = 1'b0;
`endif
        checkOutput("pc_load", pc_load, exp_pc);
        finished = 1;
      end else if (cyc > 600) begin
        check_count++;
        $display("[TB] FAIL done_timeout: got no done after %0d cycles, expected done", cyc);
        finished = 1;
      end else if (mem_req) begin
        if (b >= n) begin
          check_count++;
          $display("[TB] FAIL beat_overrun: got beat %0d, expected at most %0d beats", b, n);
          finished = 1;
        end else begin
          if (fresh) begin
            issued++;
            checkOutput("beat_idx", reg_idx, exp_idx[b]);
            checkOutput("beat_addr", mem_addr, first_m + 32'(4 * b));
            checkOutput("beat_we", mem_we, 32'(!v.l));
            if (b == 0) checkOutput("first_addr", mem_addr, v.exp_first);
            held_idx = reg_idx; held_addr = mem_addr;
            fresh = 0;
          end else begin
            checkOutput("stall_idx_hold", reg_idx, held_idx);
            checkOutput("stall_addr_hold", mem_addr, held_addr);
          end
          if (b == v.abort_at && stall_left == 0) begin
            mem_abort = 1'b1;
            mem_ready = 1'($urandom_range(0, 1));
          end else if (stall_left > 0) begin
            mem_ready = 1'b0;
            stall_left--;
          end else begin
            mem_ready = 1'b1;
          end
          #1;
          checkOutput("rf_we", rf_we, 32'(mem_ready && v.l && !mem_abort));
          if (rf_we) rf_count++;
          if (mem_abort) begin
            last_hs = cyc;
          end else if (mem_ready) begin
            b++; fresh = 1; stall_left = v.waits; last_hs = cyc;
          end
        end
      end
      if (!finished) begin
        @(negedge clk);
        mem_ready = 1'b0; mem_abort = 1'b0;
        cyc++;
      end
    end

    @(negedge clk);
    mem_ready = 1'b0; mem_abort = 1'b0;
    start = 1'b0;
    checkOutput("done_one_cycle", done, 0);
    checkOutput("wb_en_one_cycle", wb_en, 0);
    checkOutput("abort_flag_cleared", abort_flag, 0);
    @(negedge clk);
    checkOutput("idle_after_done", busy, 0);
  endtask

  initial begin
    vec_t v;
    int   n;

    // list, base, P, U, W, L, waits, abort_at, hold_start, first, wb, wb_en
    vecs[0] = '{16'h0011, 32'h0000_1000, 1'b0, 1'b1, 1'b1, 1'b1, 0, -1, 1'b0, 32'h0000_1000, 32'h0000_1008, 1'b1};
    vecs[1] = '{16'h4030, 32'h0000_2000, 1'b1, 1'b0, 1'b1, 1'b0, 0, -1, 1'b0, 32'h0000_1FF4, 32'h0000_1FF4, 1'b1};
    vecs[2] = '{16'h0006, 32'h0000_0100, 1'b1, 1'b1, 1'b0, 1'b1, 3, -1, 1'b0, 32'h0000_0104, 32'h0000_0108, 1'b0};
    vecs[3] = '{16'h00F0, 32'h0000_0040, 1'b0, 1'b0, 1'b1, 1'b1, 0,  1, 1'b0, 32'h0000_0034, 32'h0000_0030, 1'b0};
    vecs[4] = '{16'h0000, 32'h0000_0500, 1'b0, 1'b1, 1'b1, 1'b1, 0, -1, 1'b1, 32'h0000_0000, 32'h0000_0500, 1'b0};
    vecs[5] = '{16'h0003, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1, 1'b0, 0, -1, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b1};
    vecs[6] = '{16'h8000, 32'h0000_1003, 1'b1, 1'b0, 1'b1, 1'b1, 1, -1, 1'b0, 32'h0000_0FFF, 32'h0000_0FFF, 1'b1};
    vecs[7] = '{16'hFFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 0, -1, 1'b0, 32'h0000_0000, 32'h0000_0040, 1'b1};

    rst = 1'b1; start = 1'b0; reg_list = '0; base_addr = '0;
    p_bit = 1'b0; u_bit = 1'b0; w_bit = 1'b0; l_bit = 1'b0;
    mem_ready = 1'b0; mem_abort = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_mem_req", mem_req, 0);
    checkOutput("reset_mem_we", mem_we, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_abort_flag", abort_flag, 0);
    checkOutput("reset_wb_en", wb_en, 0);
    checkOutput("reset_pc_load", pc_load, 0);
    checkOutput("reset_mem_addr", mem_addr, 0);
    checkOutput("reset_wb_addr", wb_addr, 0);
    checkOutput("reset_reg_idx", reg_idx, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Reset in the middle of a 16-register load must drop the beat silently.
    @(negedge clk);
    reg_list = 16'hFFFF; base_addr = 32'h3000;
    p_bit = 1'b0; u_bit = 1'b1; w_bit = 1'b1; l_bit = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      mem_ready = 1'b1;
    end
    checkOutput("pre_reset_req", mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_wb_en", wb_en, 0);
    checkOutput("rst_rf_we", rf_we, 0);
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_done", done, 0);
    checkOutput("post_rst_busy", busy, 0);

    for (int t = 0; t < 24; t++) begin
      if (t % 8 == 7)                  v.list = 16'h0000;
      else if ($urandom_range(0, 3) == 0) v.list = 16'(1 << $urandom_range(0, 15));
      else                             v.list = 16'($urandom) & 16'($urandom | $urandom);
      v.base       = $urandom;
      v.p          = 1'($urandom_range(0, 1));
      v.u          = 1'($urandom_range(0, 1));
      v.w          = 1'($urandom_range(0, 1));
      v.l          = 1'($urandom_range(0, 1));
      v.waits      = int'($urandom_range(0, 2));
      v.hold_start = 1'($urandom_range(0, 1));
      n            = $countones(v.list);
      v.abort_at   = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      model_txn(v.list, v.base, v.p, v.u, n, v.exp_first, v.exp_wb);
      v.exp_wb_en  = v.w && (n > 0) && (v.abort_at < 0);
      applyStimulus(v);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
